tlc_phase_scheduler: RTL and testbench

- Intersection phase scheduler for the traffic light controller.
- Shares the crossing between two requesters: the farm-road vehicle sensor and a pedestrian push button.
- Sequences highway, farm and walk signals through yellow and all-red clearance phases using one internal dwell counter.
- Sits between the input synchronizers and the signal drivers; all inputs are already synchronized to Clk.

---
 rtl/tlc_phase_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_scheduler.sv
// Intersection phase scheduler: shares the crossing between the farm-road sensor and the
// pedestrian button, sequencing green/yellow/all-red phases off a single dwell counter.
module tlc_phase_scheduler #(
  parameter int unsigned CNT_W         = 31,
  parameter int unsigned HWY_MIN_GREEN = 8,
  parameter int unsigned FARM_GREEN    = 6,
  parameter int unsigned WALK_TIME     = 5,
  parameter int unsigned YELLOW_TIME   = 3,
  parameter int unsigned ALLRED_TIME   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmSensor,
  input  logic       pedButton,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       walkSignal,
  output logic [2:0] state,
  output logic       farmPending,
  output logic       pedPending
);

  typedef enum logic [2:0] {
    StHg   = 3'd0,
    StHy   = 3'd1,
    StAr1  = 3'd2,
    StFg   = 3'd3,
    StFy   = 3'd4,
    StWalk = 3'd5,
    StAr2  = 3'd6,
    StBad  = 3'd7
  } state_e;

  localparam logic [1:0] LampGreen  = 2'b00;
  localparam logic [1:0] LampYellow = 2'b01;
  localparam logic [1:0] LampRed    = 2'b10;

  // Last count value of each phase; a phase of dwell T exits when the count reaches T-1.
  localparam logic [CNT_W-1:0] HwyLast    = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FarmLast   = CNT_W'(FARM_GREEN - 1);
  localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AllredLast = CNT_W'(ALLRED_TIME - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_dwell_last;
  logic             w_dwell_done;
  logic             r_farm_pend;
  logic             r_ped_pend;
  logic             r_last_farm;
  logic             w_farm_pend_next;
  logic             w_ped_pend_next;
  logic             w_last_farm_next;
  logic             w_grant_farm;
  logic             w_grant_ped;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= StHg;
      r_count     <= '0;
      r_farm_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_last_farm <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_farm_pend <= w_farm_pend_next;
      r_ped_pend  <= w_ped_pend_next;
      r_last_farm <= w_last_farm_next;
    end
  end

  always_comb begin
    w_dwell_last = '1;
    case (r_state)
      StHg:        w_dwell_last = HwyLast;
      StHy, StFy:  w_dwell_last = YellowLast;
      StAr1, StAr2: w_dwell_last = AllredLast;
      StFg:        w_dwell_last = FarmLast;
      StWalk:      w_dwell_last = WalkLast;
      default:     w_dwell_last = '1;
    endcase
  end

  assign w_dwell_done = (r_count == w_dwell_last);

  always_comb begin
    w_state_next = r_state;
    w_grant_farm = 1'b0;
    w_grant_ped  = 1'b0;
    case (r_state)
      StHg: begin
        if ((r_count >= HwyLast) && (r_farm_pend || r_ped_pend)) w_state_next = StHy;
      end
      StHy:   if (w_dwell_done) w_state_next = StAr1;
      StAr1: begin
        if (w_dwell_done) begin
          // On a tie, serve whoever was not served last.
          if (r_farm_pend && (!r_ped_pend || !r_last_farm)) begin
            w_state_next = StFg;
            w_grant_farm = 1'b1;
          end else if (r_ped_pend) begin
            w_state_next = StWalk;
            w_grant_ped  = 1'b1;
          end else begin
            w_state_next = StAr2;
          end
        end
      end
      StFg:   if (w_dwell_done) w_state_next = StFy;
      StFy:   if (w_dwell_done) w_state_next = StAr2;
      StWalk: if (w_dwell_done) w_state_next = StAr2;
      StAr2:  if (w_dwell_done) w_state_next = StHg;
      default: w_state_next = StHg;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_state_next != r_state) begin
      w_count_next = '0;
    end else if (r_count != '1) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_comb begin
    w_farm_pend_next = r_farm_pend;
    w_ped_pend_next  = r_ped_pend;
    w_last_farm_next = r_last_farm;
    if (farmSensor && (r_state != StFg) && (r_state != StFy)) w_farm_pend_next = 1'b1;
    if (pedButton && (r_state != StWalk)) w_ped_pend_next = 1'b1;
    if (w_grant_farm) begin
      w_farm_pend_next = 1'b0;
      w_last_farm_next = 1'b1;
    end
    if (w_grant_ped) begin
      w_ped_pend_next  = 1'b0;
      w_last_farm_next = 1'b0;
    end
  end

  always_comb begin
    highwaySignal = LampRed;
    farmSignal    = LampRed;
    walkSignal    = 1'b0;
    case (r_state)
      StHg:   highwaySignal = LampGreen;
      StHy:   highwaySignal = LampYellow;
      StFg:   farmSignal    = LampGreen;
      StFy:   farmSignal    = LampYellow;
      StWalk: walkSignal    = 1'b1;
      default: ;
    endcase
  end

  assign state       = r_state;
  assign farmPending = r_farm_pend;
  assign pedPending  = r_ped_pend;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: directed phase-sequence tables, an async-reset corner case,
// and random requests checked against a phase-level reference model.
module tb_tlc_phase_scheduler;

  logic       Clk;
  logic       Rst;
  logic       farmSensor;
  logic       pedButton;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic       walkSignal;
  logic [2:0] state;
  logic       farmPending;
  logic       pedPending;

  int n_cmp = 0;
  int n_bad = 0;

  tlc_phase_scheduler dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .farmSensor   (farmSensor),
    .pedButton    (pedButton),
    .highwaySignal(highwaySignal),
    .farmSignal   (farmSignal),
    .walkSignal   (walkSignal),
    .state        (state),
    .farmPending  (farmPending),
    .pedPending   (pedPending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: phase index, cycles already spent in it, request flags, who went last.
  typedef struct {
    int st;
    int held;
    bit fp;
    bit pp;
    bit last_farm;
  } model_t;

  model_t m;

  function automatic int dwell(int st);
    case (st)
      0: return 8;
      1, 4: return 3;
      2, 6: return 2;
      3: return 6;
      5: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic model_t step(model_t s, bit f, bit p);
    model_t n;
    bit     gf;
    bit     gp;
    bit     done;
    n    = s;
    gf   = 1'b0;
    gp   = 1'b0;
    done = (s.held + 1 >= dwell(s.st));
    case (s.st)
      0: if (done && (s.fp || s.pp)) n.st = 1;
      1: if (done) n.st = 2;
      2: if (done) begin
        if (s.fp && (!s.pp || !s.last_farm)) begin n.st = 3; gf = 1'b1; end
        else if (s.pp) begin n.st = 5; gp = 1'b1; end
        else n.st = 6;
      end
      3: if (done) n.st = 4;
      4: if (done) n.st = 6;
      5: if (done) n.st = 6;
      6: if (done) n.st = 0;
      default: n.st = 0;
    endcase
    n.held = (n.st != s.st) ? 0 : s.held + 1;
    n.fp   = gf ? 1'b0 : (s.fp || (f && s.st != 3 && s.st != 4));
    n.pp   = gp ? 1'b0 : (s.pp || (p && s.st != 5));
    if (gf) n.last_farm = 1'b1;
    if (gp) n.last_farm = 1'b0;
    return n;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m <= '{st: 0, held: 0, fp: 1'b0, pp: 1'b0, last_farm: 1'b0};
    else      m <= step(m, farmSensor, pedButton);
  end

  function automatic int lamp_hwy(int st);
    return (st == 0) ? 0 : (st == 1) ? 1 : 2;
  endfunction

  function automatic int lamp_farm(int st);
    return (st == 3) ? 0 : (st == 4) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model.state", int'(state), m.st);
    chk("model.highway", int'(highwaySignal), lamp_hwy(m.st));
    chk("model.farm", int'(farmSignal), lamp_farm(m.st));
    chk("model.walk", int'(walkSignal), (m.st == 5) ? 1 : 0);
    chk("model.farmPending", int'(farmPending), int'(m.fp));
    chk("model.pedPending", int'(pedPending), int'(m.pp));
  endtask

  // Reset is released on a falling edge; the following cycle is cycle 0.
  task automatic apply_reset();
    @(negedge Clk);
    Rst        = 1'b0;
    farmSensor = 1'b0;
    pedButton  = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  typedef struct {
    int test;
    int st;
    int hw;
    int fm;
    int wk;
    int len;
    int fp_last;  // expected farmPending in the segment's last cycle, 2 = don't care
  } seg_t;

  seg_t segs[$];

  task automatic add(input int t, input int st, input int hw, input int fm, input int wk,
                     input int len, input int fpl);
    seg_t s;
    s.test = t; s.st = st; s.hw = hw; s.fm = fm; s.wk = wk; s.len = len; s.fp_last = fpl;
    segs.push_back(s);
  endtask

  function automatic bit stim_farm(int t, int cyc);
    case (t)
      0: return cyc == 2;
      2: return (cyc == 2) || (cyc == 25);
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit stim_ped(int t, int cyc);
    case (t)
      1: return cyc == 20;
      2: return (cyc == 2) || (cyc == 25);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    Rst        = 1'b0;
    farmSensor = 1'b0;
    pedButton  = 1'b0;

    // Farm pulse at cycle 2.
    add(0, 0, 0, 2, 0, 8, 1); add(0, 1, 1, 2, 0, 3, 2); add(0, 2, 2, 2, 0, 2, 2);
    add(0, 3, 2, 0, 0, 6, 0); add(0, 4, 2, 1, 0, 3, 2); add(0, 6, 2, 2, 0, 2, 0);
    add(0, 0, 0, 2, 0, 4, 0);
    // Ped pulse 20 cycles into HG.
    add(1, 0, 0, 2, 0, 22, 2); add(1, 1, 1, 2, 0, 3, 2); add(1, 2, 2, 2, 0, 2, 2);
    add(1, 5, 2, 2, 1, 5, 2); add(1, 6, 2, 2, 0, 2, 2); add(1, 0, 0, 2, 0, 3, 2);
    // Simultaneous pairs at cycles 2 and 25.
    add(2, 0, 0, 2, 0, 8, 1); add(2, 1, 1, 2, 0, 3, 2); add(2, 2, 2, 2, 0, 2, 2);
    add(2, 3, 2, 0, 0, 6, 0); add(2, 4, 2, 1, 0, 3, 2); add(2, 6, 2, 2, 0, 2, 0);
    add(2, 0, 0, 2, 0, 8, 1); add(2, 1, 1, 2, 0, 3, 2); add(2, 2, 2, 2, 0, 2, 2);
    add(2, 5, 2, 2, 1, 5, 1); add(2, 6, 2, 2, 0, 2, 1); add(2, 0, 0, 2, 0, 8, 1);
    add(2, 1, 1, 2, 0, 3, 2); add(2, 2, 2, 2, 0, 2, 2); add(2, 3, 2, 0, 0, 6, 0);
    add(2, 4, 2, 1, 0, 3, 2); add(2, 6, 2, 2, 0, 2, 0); add(2, 0, 0, 2, 0, 3, 0);
    // Farm sensor held high.
    for (int r = 0; r < 2; r++) begin
      add(3, 0, 0, 2, 0, 8, 1); add(3, 1, 1, 2, 0, 3, 2); add(3, 2, 2, 2, 0, 2, 2);
      add(3, 3, 2, 0, 0, 6, 0); add(3, 4, 2, 1, 0, 3, 0); add(3, 6, 2, 2, 0, 2, 1);
    end
    add(3, 0, 0, 2, 0, 2, 1);

    // Idle after reset: highway stays green.
    apply_reset();
    for (int c = 0; c < 100; c++) begin
      chk("idle.state", int'(state), 0);
      chk("idle.highway", int'(highwaySignal), 0);
      chk("idle.farm", int'(farmSignal), 2);
      chk("idle.walk", int'(walkSignal), 0);
      chk("idle.pending", int'({farmPending, pedPending}), 0);
      @(negedge Clk);
    end

    for (int t = 0; t < 4; t++) begin
      int cyc;
      apply_reset();
      cyc = 0;
      foreach (segs[i]) begin
        if (segs[i].test == t) begin
          for (int k = 0; k < segs[i].len; k++) begin
            farmSensor = stim_farm(t, cyc);
            pedButton  = stim_ped(t, cyc);
            chk($sformatf("seq%0d.c%0d.state", t, cyc), int'(state), segs[i].st);
            chk($sformatf("seq%0d.c%0d.highway", t, cyc), int'(highwaySignal), segs[i].hw);
            chk($sformatf("seq%0d.c%0d.farm", t, cyc), int'(farmSignal), segs[i].fm);
            chk($sformatf("seq%0d.c%0d.walk", t, cyc), int'(walkSignal), segs[i].wk);
            if (k == segs[i].len - 1 && segs[i].fp_last != 2)
              chk($sformatf("seq%0d.c%0d.farmPending", t, cyc), int'(farmPending),
                  segs[i].fp_last);
            if (t == 0 && cyc == 3) chk("seq0.fp_latched", int'(farmPending), 1);
            check_model();
            @(negedge Clk);
            cyc++;
          end
        end
      end
    end

    // Asynchronous reset at count 3 of FG, with a pedestrian request outstanding.
    apply_reset();
    farmSensor = 1'b1;
    @(negedge Clk);
    farmSensor = 1'b0;
    for (int c = 0; c < 100 && state != 3'd3; c++) @(negedge Clk);
    chk("rst.fg_reached", int'(state), 3);
    pedButton = 1'b1;
    @(negedge Clk);
    pedButton = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst.pedPending_before", int'(pedPending), 1);
    #2 Rst = 1'b0;
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.highway", int'(highwaySignal), 0);
    chk("rst.farm", int'(farmSignal), 2);
    chk("rst.walk", int'(walkSignal), 0);
    chk("rst.farmPending", int'(farmPending), 0);
    chk("rst.pedPending", int'(pedPending), 0);
    @(negedge Clk);
    Rst = 1'b1;

    // Random requests with occasional mid-cycle resets.
    for (int c = 0; c < 4000; c++) begin
      farmSensor = ($urandom_range(0, 9) == 0);
      pedButton  = ($urandom_range(0, 11) == 0);
      check_model();
      if ($urandom_range(0, 499) == 0) begin
        #3 Rst = 1'b0;
        #1 check_model();
        @(negedge Clk);
        Rst = 1'b1;
      end else begin
        @(negedge Clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
